// File: rtl/pipe_mem_access_if.sv
// -----------------------------------------------------------------------------
// pipe_mem_access_if
//   Request/acknowledge data-memory bus between the MEM pipeline stage
//   (master) and the data memory (slave).
//
//   req    master->slave  access request, held until the ack cycle inclusive
//   we     master->slave  1 = write, 0 = read
//   be     master->slave  byte enables, little-endian lanes
//   addr   master->slave  word-aligned byte address
//   wdata  master->slave  store data, replicated across the active lanes
//   rdata  slave->master  read data, valid together with ack
//   ack    slave->master  access complete
// -----------------------------------------------------------------------------
interface pipe_mem_access_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req, we, be, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/pipe_mem_access.sv
// -----------------------------------------------------------------------------
// pipe_mem_access
//   MEM stage of the 5-stage pipeline. Takes the EXE results, performs sized,
//   aligned loads and stores over a req/ack data-memory bus, stalls upstream
//   while an access is outstanding and presents one MEM/WB result per
//   accepted instruction.
//
//   Parameter
//     TIMEOUT   cycles in BUSY without ack before the access is aborted
//               (0 = wait forever)
//
//   Ports
//     clock, resetn            rising-edge clock, async active-low reset
//     e_valid                  EXE result valid
//     e_w / e_h / e_b          access size (w > h > b, none = word)
//     e_z                      zero-extend load (lbu/lhu)
//     e_rmem / e_wmem          load / store (both set = store)
//     e_wreg, wa_e             register write enable / address
//     wd                       ALU result or effective address
//     e_st                     store data
//     stall                    upstream must hold EXE outputs
//     dm                       data-memory bus (master side)
//     m_valid                  one-cycle pulse per retired instruction
//     m_wreg, m_wa, m_wd       writeback enable / address / data
//     misalign                 one-cycle pulse: misaligned access suppressed
//     bus_err                  one-cycle pulse: access aborted on timeout
// -----------------------------------------------------------------------------
module pipe_mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              e_valid,
  input  logic              e_w,
  input  logic              e_h,
  input  logic              e_b,
  input  logic              e_z,
  input  logic              e_rmem,
  input  logic              e_wmem,
  input  logic              e_wreg,
  input  logic [4:0]        wa_e,
  input  logic [31:0]       wd,
  input  logic [31:0]       e_st,
  output logic              stall,
  pipe_mem_access_if.master dm,
  output logic              m_valid,
  output logic              m_wreg,
  output logic [4:0]        m_wa,
  output logic [31:0]       m_wd,
  output logic              misalign,
  output logic              bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Everything about the outstanding access, frozen at acceptance so the bus
  // stays stable while upstream is free to change under stall.
  typedef struct packed {
    logic        we;
    logic        load;
    logic        z;
    size_t       size;
    logic        wreg;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] wdata;
  } access_t;

  state_t             state_q, state_d;
  access_t            acc;
  logic [CNT_W-1:0]   tmo_cnt;

  // EXE-side decode
  size_t              e_size;
  logic               mem_op;
  logic               misal;
  logic [3:0]         e_be;
  logic [31:0]        e_wdata;

  // FSM events
  logic               accept;
  logic               go_busy;
  logic               done_ack;
  logic               abort;
  logic               tmo_hit;

  logic [31:0]        load_data;

  // ---------------------------------------------------------------------------
  // EXE decode: access size, alignment and store lane placement
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    e_size  = SZ_W;
    e_be    = 4'b1111;
    e_wdata = e_st;

    if (e_w)      e_size = SZ_W;
    else if (e_h) e_size = SZ_H;
    else if (e_b) e_size = SZ_B;

    mem_op = e_rmem | e_wmem;
    misal  = ((e_size == SZ_H) && wd[0]) ||
             ((e_size == SZ_W) && (wd[1:0] != 2'b00));

    case (e_size)
      SZ_B: begin
        e_be    = 4'b0001 << wd[1:0];
        e_wdata = {4{e_st[7:0]}};
      end
      SZ_H: begin
        e_be    = wd[1] ? 4'b1100 : 4'b0011;
        e_wdata = {2{e_st[15:0]}};
      end
      default: begin
        e_be    = 4'b1111;
        e_wdata = e_st;
      end
    endcase
  end

  // Counter value at which the next silent BUSY cycle would reach TIMEOUT.
  assign tmo_hit = (TIMEOUT != 0) && (32'(tmo_cnt) == TIMEOUT - 32'd1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and transition events
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    go_busy  = 1'b0;
    done_ack = 1'b0;
    abort    = 1'b0;

    case (state_q)
      IDLE: begin
        if (e_valid) begin
          accept = 1'b1;
          // Misaligned accesses retire immediately without touching the bus.
          if (mem_op && !misal) begin
            go_busy = 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // An ack arriving in the timeout cycle still completes the access.
        if (dm.ack) begin
          done_ack = 1'b1;
          state_d  = IDLE;
        end else if (tmo_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. The bus is driven from the state flop and the captured
  // access, so it is glitch-free and drops the moment reset asserts.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall    = (state_q == BUSY);
    dm.req   = (state_q == BUSY);
    dm.we    = (state_q == BUSY) & acc.we;
    dm.be    = (state_q == BUSY) ? acc.be    : 4'b0000;
    dm.addr  = (state_q == BUSY) ? {acc.wd[31:2], 2'b00} : 32'd0;
    dm.wdata = (state_q == BUSY) ? acc.wdata : 32'd0;

    // Load formatting: pick the addressed lane and extend to 32 bits.
    load_data = dm.rdata;
    case (acc.size)
      SZ_B: begin
        load_data[7:0]  = dm.rdata[{acc.wd[1:0], 3'b000} +: 8];
        load_data[31:8] = {24{~acc.z & load_data[7]}};
      end
      SZ_H: begin
        load_data[15:0]  = dm.rdata[{acc.wd[1], 4'b0000} +: 16];
        load_data[31:16] = {16{~acc.z & load_data[15]}};
      end
      default: load_data = dm.rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Access capture, timeout counter and MEM/WB result register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    if (!resetn) begin
      acc      <= '0;
      tmo_cnt  <= '0;
      m_valid  <= 1'b0;
      m_wreg   <= 1'b0;
      m_wa     <= 5'd0;
      m_wd     <= 32'd0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      // Pulses default low; the branches below raise them for one cycle.
      m_valid  <= 1'b0;
      m_wreg   <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;

      if (go_busy) begin
        acc.we    <= e_wmem;
        acc.load  <= e_rmem & ~e_wmem;
        acc.z     <= e_z;
        acc.size  <= e_size;
        acc.wreg  <= e_wreg;
        acc.wa    <= wa_e;
        acc.wd    <= wd;
        acc.be    <= e_be;
        acc.wdata <= e_wdata;
        tmo_cnt   <= '0;
      end else if ((state_q == BUSY) && !dm.ack) begin
        tmo_cnt   <= tmo_cnt + CNT_W'(1);
      end

      // Retire without a bus access: plain ALU result or misaligned access.
      if (accept && !go_busy) begin
        m_valid  <= 1'b1;
        m_wreg   <= mem_op ? 1'b0 : e_wreg;
        misalign <= mem_op;
        m_wa     <= wa_e;
        m_wd     <= wd;
      end

      if (done_ack) begin
        m_valid <= 1'b1;
        m_wreg  <= acc.load & acc.wreg;
        m_wa    <= acc.wa;
        m_wd    <= acc.load ? load_data : acc.wd;
      end

      if (abort) begin
        m_valid <= 1'b1;
        bus_err <= 1'b1;
        m_wa    <= acc.wa;
        m_wd    <= acc.wd;
      end
    end
  end

endmodule
